// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the fetch and data requesters, with data having priority.
// Optional statistics counters are enabled by defining MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          mem_rd,
  input  logic          mem_wr,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_done,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ack,
  input  logic [DW-1:0] m_rdata,
  output logic          stall
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [15:0]   stat_conflicts,
  output logic [15:0]   stat_wait
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;
  state_t r_state;
  logic w_mem_any;
  assign w_mem_any = mem_rd | mem_wr;
  assign stall = ~reset & ((if_req & ~if_done) | (w_mem_any & ~mem_done));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      mem_rdata <= '0;
      mem_done  <= 1'b0;
      m_req     <= 1'b0;
      m_we      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_mem_any) begin
            m_req   <= 1'b1;
            m_we    <= mem_wr;
            m_addr  <= mem_addr;
            m_wdata <= mem_wdata;
            r_state <= BUSY_MEM;
          end else if (if_req) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_addr  <= if_addr;
            r_state <= BUSY_IF;
          end
        end
        BUSY_IF: if (m_ack) begin
          m_req    <= 1'b0;
          if_rdata <= m_rdata;
          if_done  <= 1'b1;
          r_state  <= RESP;
        end
        BUSY_MEM: if (m_ack) begin
          m_req    <= 1'b0;
          if (!m_we) mem_rdata <= m_rdata;
          mem_done <= 1'b1;
          r_state  <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
`ifdef MEM_PORT_ARBITER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_conflicts <= '0;
      stat_wait      <= '0;
    end else begin
      if (r_state == IDLE && if_req && w_mem_any && !(&stat_conflicts)) stat_conflicts <= stat_conflicts + 1'b1;
      if (stall && !(&stat_wait)) stat_wait <= stat_wait + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, handshake timing, reset and flush behaviour.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        stall;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0] stat_conflicts;
  logic [15:0] stat_wait;
`endif
  int n_checks = 0;
  int n_pass = 0;
  always #5 clk = ~clk;
  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata), .stall(stall)
`ifdef MEM_PORT_ARBITER_STATS_EN
    , .stat_conflicts(stat_conflicts), .stat_wait(stat_wait)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    reset = 1'b1; if_req = 1'b1; if_addr = '0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_addr = '0; mem_wdata = '0; m_ack = 1'b0; m_rdata = '0;
    tick(); tick();
    n_checks++; if (m_req !== 1'b0) $display("FAIL rst_m_req: got %b want 0", m_req); else n_pass++;
    n_checks++; if (if_done !== 1'b0 || mem_done !== 1'b0) $display("FAIL rst_done: got %b%b want 00", if_done, mem_done); else n_pass++;
    n_checks++; if (stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall); else n_pass++;
    n_checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) $display("FAIL rst_rdata: got %h %h want 0 0", if_rdata, mem_rdata); else n_pass++;
    if_req = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  task automatic test_fetch;
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    n_checks++; if (stall !== 1'b1) $display("FAIL fetch_stall_pre: got %b want 1", stall); else n_pass++;
    tick();
    n_checks++; if ({m_req, m_we, m_addr} !== {2'b10, 32'h40}) $display("FAIL fetch_issue: got req=%b we=%b addr=%h want 1 0 40", m_req, m_we, m_addr); else n_pass++;
    tick();
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h40 || if_done !== 1'b0) $display("FAIL fetch_hold: got req=%b addr=%h done=%b want 1 40 0", m_req, m_addr, if_done); else n_pass++;
    m_ack = 1'b1; m_rdata = 32'h8C010004;
    tick();
    n_checks++; if ({m_req, if_done, stall} !== 3'b010) $display("FAIL fetch_ack: got req=%b done=%b stall=%b want 0 1 0", m_req, if_done, stall); else n_pass++;
    n_checks++; if (if_rdata !== 32'h8C010004) $display("FAIL fetch_rdata: got %h want 8c010004", if_rdata); else n_pass++;
    m_ack = 1'b0; if_req = 1'b0;
    tick();
    n_checks++; if (if_done !== 1'b0 || m_req !== 1'b0) $display("FAIL fetch_pulse: got done=%b req=%b want 0 0", if_done, m_req); else n_pass++;
    tick();
  endtask
  task automatic test_simultaneous;
    if_req = 1'b1; if_addr = 32'h200; mem_rd = 1'b1; mem_addr = 32'h100;
    tick();
    n_checks++; if ({m_req, m_we, m_addr} !== {2'b10, 32'h100}) $display("FAIL simul_mem_first: got req=%b we=%b addr=%h want 1 0 100", m_req, m_we, m_addr); else n_pass++;
    m_ack = 1'b1; m_rdata = 32'hCAFE0001;
    tick();
    n_checks++; if ({mem_done, if_done, stall} !== 3'b101) $display("FAIL simul_mem_done: got mdone=%b idone=%b stall=%b want 1 0 1", mem_done, if_done, stall); else n_pass++;
    n_checks++; if (mem_rdata !== 32'hCAFE0001) $display("FAIL simul_mem_rdata: got %h want cafe0001", mem_rdata); else n_pass++;
    m_ack = 1'b0; mem_rd = 1'b0;
    tick();
    n_checks++; if (m_req !== 1'b0 || mem_done !== 1'b0) $display("FAIL simul_resp: got req=%b mdone=%b want 0 0", m_req, mem_done); else n_pass++;
    tick();
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h200) $display("FAIL simul_if_issue: got req=%b addr=%h want 1 200", m_req, m_addr); else n_pass++;
    m_ack = 1'b1; m_rdata = 32'h11112222;
    tick();
    n_checks++; if (if_done !== 1'b1 || if_rdata !== 32'h11112222) $display("FAIL simul_if_done: got done=%b rdata=%h want 1 11112222", if_done, if_rdata); else n_pass++;
    m_ack = 1'b0; if_req = 1'b0;
    tick(); tick();
`ifdef MEM_PORT_ARBITER_STATS_EN
    n_checks++; if (stat_conflicts !== 16'd1) $display("FAIL stat_conflicts: got %0d want 1", stat_conflicts); else n_pass++;
`endif
  endtask
  task automatic test_write;
    mem_wr = 1'b1; mem_addr = 32'h8; mem_wdata = 32'hDEADBEEF;
    tick();
    n_checks++; if ({m_req, m_we, m_addr, m_wdata} !== {2'b11, 32'h8, 32'hDEADBEEF}) $display("FAIL write_issue: got req=%b we=%b addr=%h wdata=%h want 1 1 8 deadbeef", m_req, m_we, m_addr, m_wdata); else n_pass++;
    m_ack = 1'b1; m_rdata = 32'h12345678;
    tick();
    n_checks++; if (mem_done !== 1'b1 || mem_rdata !== 32'hCAFE0001) $display("FAIL write_done: got done=%b rdata=%h want 1 cafe0001", mem_done, mem_rdata); else n_pass++;
    m_ack = 1'b0; mem_wr = 1'b0;
    tick();
    n_checks++; if (mem_done !== 1'b0) $display("FAIL write_pulse: got %b want 0", mem_done); else n_pass++;
    tick();
  endtask
  task automatic test_held;
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    m_ack = 1'b1; m_rdata = 32'hA5A5A5A5;
    tick();
    n_checks++; if (if_done !== 1'b1 || m_req !== 1'b0) $display("FAIL held_done: got done=%b req=%b want 1 0", if_done, m_req); else n_pass++;
    m_ack = 1'b0;
    tick();
    n_checks++; if (m_req !== 1'b0 || if_done !== 1'b0) $display("FAIL held_resp_no_reissue: got req=%b done=%b want 0 0", m_req, if_done); else n_pass++;
    tick();
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h44) $display("FAIL held_reissue: got req=%b addr=%h want 1 44", m_req, m_addr); else n_pass++;
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0; if_req = 1'b0;
    tick(); tick();
  endtask
  task automatic test_reset_busy;
    mem_rd = 1'b1; mem_addr = 32'h300;
    tick();
    n_checks++; if (m_req !== 1'b1) $display("FAIL rbusy_issue: got %b want 1", m_req); else n_pass++;
    reset = 1'b1;
    tick();
    n_checks++; if (m_req !== 1'b0) $display("FAIL rbusy_drop: got %b want 0", m_req); else n_pass++;
    reset = 1'b0; mem_rd = 1'b0; m_ack = 1'b1; m_rdata = 32'h77777777;
    tick();
    n_checks++; if ({mem_done, if_done, m_req} !== 3'b000 || mem_rdata !== 32'h0) $display("FAIL rbusy_late_ack: got mdone=%b idone=%b req=%b rdata=%h want 0 0 0 0", mem_done, if_done, m_req, mem_rdata); else n_pass++;
    m_ack = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    tick();
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h80) $display("FAIL rbusy_idle: got req=%b addr=%h want 1 80", m_req, m_addr); else n_pass++;
    m_ack = 1'b1;
    tick();
    m_ack = 1'b0; if_req = 1'b0;
    tick(); tick();
  endtask
  task automatic test_flush;
    if_req = 1'b1; if_addr = 32'h60;
    tick();
    if_req = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall); else n_pass++;
    tick();
    n_checks++; if (m_req !== 1'b1 || m_addr !== 32'h60) $display("FAIL flush_hold: got req=%b addr=%h want 1 60", m_req, m_addr); else n_pass++;
    m_ack = 1'b1; m_rdata = 32'h55;
    tick();
    n_checks++; if (if_done !== 1'b1 || if_rdata !== 32'h55) $display("FAIL flush_done: got done=%b rdata=%h want 1 55", if_done, if_rdata); else n_pass++;
    m_ack = 1'b0;
    tick();
    n_checks++; if (if_done !== 1'b0) $display("FAIL flush_pulse: got %b want 0", if_done); else n_pass++;
    tick();
    n_checks++; if (m_req !== 1'b0) $display("FAIL flush_no_reissue: got %b want 0", m_req); else n_pass++;
  endtask
  initial begin
    test_reset();
    test_fetch();
    test_simultaneous();
    test_write();
    test_held();
    test_reset_busy();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
